// File: rtl/pwm_pkg.sv
// pwm_pkg: shared state encoding, default sizing and duty compare for the PWM frame sequencer
package pwm_pkg;
   typedef enum logic [2:0] {IDLE, SHIFT, LATCH, CLR_SHIFT, CLR_LATCH} state_t;
   localparam int NCH_DEF = 8;
   localparam int DW_DEF = 8;
   localparam int PERIOD_DEF = 100;
   function automatic logic duty_on(input logic [31:0] count, input logic [31:0] duty);
      return count < duty;
   endfunction
endpackage

// File: rtl/pwm_frame_sequencer_if.sv
// pwm_frame_sequencer_if: duty write handshake between a host and the sequencer
interface pwm_frame_sequencer_if import pwm_pkg::*; #(parameter int NCH = NCH_DEF, parameter int DW = DW_DEF);
   logic cfg_valid;
   logic cfg_ready;
   logic [$clog2(NCH)-1:0] cfg_chan;
   logic [DW-1:0] cfg_duty;
   modport master (output cfg_valid, cfg_chan, cfg_duty, input cfg_ready);
   modport slave (input cfg_valid, cfg_chan, cfg_duty, output cfg_ready);
endinterface

// File: rtl/pwm_duty_bank.sv
// pwm_duty_bank: pending/active duty registers; writes land in pending, load copies all to active
module pwm_duty_bank import pwm_pkg::*; #(
   parameter int NCH = NCH_DEF,
   parameter int DW = DW_DEF,
   localparam int CW = $clog2(NCH)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          we,
   input  logic [CW-1:0] wchan,
   input  logic [DW-1:0] wduty,
   input  logic          load,
   input  logic [CW-1:0] rd_ch,
   output logic [DW-1:0] rd_duty
);
   logic [DW-1:0] pending [NCH];
   logic [DW-1:0] active [NCH];
   always_ff @(posedge clk) begin
      if (reset) begin
         pending <= '{default: '0};
         active <= '{default: '0};
      end else begin
         if (we && 32'(wchan) < NCH) pending[wchan] <= wduty;
         if (load) active <= pending;
      end
   end
   assign rd_duty = active[rd_ch];
endmodule

// File: rtl/pwm_frame_sequencer.sv
// pwm_frame_sequencer: shares one period counter across NCH channels, emitting one serial
// compare frame plus latch per counter step, with duty updates applied only at period wrap
module pwm_frame_sequencer import pwm_pkg::*; #(
   parameter int NCH = NCH_DEF,
   parameter int DW = DW_DEF,
   parameter int PERIOD = PERIOD_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic enable,
   pwm_frame_sequencer_if.slave cfg,
   output logic sr_data,
   output logic sr_shift,
   output logic sr_latch,
   output logic period_start,
   output logic busy
);
   localparam int CW = $clog2(NCH);
   state_t state, nxt;
   logic [DW-1:0] count, count_n, duty;
   logic [CW-1:0] ch, ch_n;
   logic wrap, load;
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         count <= '0;
         ch <= CW'(NCH-1);
      end else begin
         state <= nxt;
         count <= count_n;
         ch <= ch_n;
      end
   end
   always_comb begin
      nxt = state;
      count_n = count;
      ch_n = ch;
      case (state)
         IDLE: begin
            count_n = '0;
            ch_n = CW'(NCH-1);
            nxt = enable ? SHIFT : IDLE;
         end
         SHIFT, CLR_SHIFT: begin
            ch_n = ch - CW'(1);
            if (ch == '0) nxt = (state == SHIFT) ? LATCH : CLR_LATCH;
         end
         LATCH: begin
            count_n = wrap ? '0 : count + DW'(1);
            ch_n = CW'(NCH-1);
            nxt = enable ? SHIFT : CLR_SHIFT;
         end
         default: begin
            count_n = '0;
            nxt = IDLE;
         end
      endcase
   end
   assign wrap = (count == DW'(PERIOD-1));
   // writes are refused in the wrap cycle so none can race the pending->active copy
   assign load = (state == IDLE) || (state == LATCH && wrap);
   assign cfg.cfg_ready = !(state == LATCH && wrap);
   assign sr_shift = (state == SHIFT) || (state == CLR_SHIFT);
   assign sr_data = (state == SHIFT) && duty_on(32'(count), 32'(duty));
   assign sr_latch = (state == LATCH) || (state == CLR_LATCH);
   assign period_start = (state == SHIFT) && (ch == CW'(NCH-1)) && (count == '0);
   assign busy = (state != IDLE);
   pwm_duty_bank #(.NCH(NCH), .DW(DW)) bank (
      .clk(clk),
      .reset(reset),
      .we(cfg.cfg_valid && cfg.cfg_ready),
      .wchan(cfg.cfg_chan),
      .wduty(cfg.cfg_duty),
      .load(load),
      .rd_ch(ch),
      .rd_duty(duty)
   );
endmodule

// File: tb/tb_pwm_frame_sequencer.sv
// tb_pwm_frame_sequencer: frame-level scoreboard of the sequencer driving a modelled shift chain
module tb_pwm_frame_sequencer;
   localparam int NCH = 8;
   localparam int DW = 8;
   localparam int PERIOD = 100;
   localparam int CW = $clog2(NCH);
   localparam int FL = NCH + 1;
   typedef struct {int chan; int duty; int hits;} vec_t;
   typedef struct {logic [NCH-1:0] bits; bit ps; bit wrap; bit clr;} exp_t;
   logic clk = 0, reset = 1, enable = 0;
   logic sr_data, sr_shift, sr_latch, period_start, busy;
   pwm_frame_sequencer_if #(.NCH(NCH), .DW(DW)) cfg();
   pwm_frame_sequencer #(.NCH(NCH), .DW(DW), .PERIOD(PERIOD)) dut (
      .clk(clk), .reset(reset), .enable(enable), .cfg(cfg),
      .sr_data(sr_data), .sr_shift(sr_shift), .sr_latch(sr_latch),
      .period_start(period_start), .busy(busy)
   );
   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;
   int n_chk = 0, n_fail = 0;
   exp_t q[$];
   int m_pend[NCH], m_act[NCH], hits[NCH], exp3[NCH];
   int m_cnt = 0, nf = 0, t_en = 0, last_ps = -1, nsh = 0;
   bit saw_ps = 0;
   logic [NCH-1:0] sreg = '0;
   vec_t tbl[12];

   task automatic chk(input string n, input int a, input int e);
      n_chk++;
      if (a != e) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", n, a, e, cyc);
      end
   endtask

   // external shift chain + latch model; each latch pops one expected frame
   always @(negedge clk) begin
      exp_t e;
      if (reset) begin
         nsh = 0;
         sreg = '0;
         saw_ps = 0;
      end else begin
         if (period_start) begin
            saw_ps = 1;
            if (last_ps >= 0) chk("ps_interval", cyc - last_ps, FL * PERIOD);
            last_ps = cyc;
         end
         if (sr_shift) begin
            sreg = {sreg[NCH-2:0], sr_data};
            nsh++;
         end
         if (sr_latch) begin
            if (q.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL unexpected_latch: got latch expected none (cycle %0d)", cyc);
            end else begin
               e = q.pop_front();
               chk("frame", int'(sreg), int'(e.bits));
               chk("frame_len", nsh, NCH);
               chk("period_start", int'(saw_ps), int'(e.ps));
               chk("cfg_ready_latch", int'(cfg.cfg_ready), int'(!e.wrap));
               if (!e.clr) for (int i = 0; i < NCH; i++) hits[i] += int'(sreg[i]);
            end
            nsh = 0;
            saw_ps = 0;
         end
      end
   end

   task automatic push_frame();
      exp_t e;
      for (int i = 0; i < NCH; i++) e.bits[i] = (m_cnt < m_act[i]);
      e.ps = (m_cnt == 0);
      e.wrap = (m_cnt == PERIOD - 1);
      e.clr = 0;
      q.push_back(e);
      if (e.wrap) begin
         m_cnt = 0;
         m_act = m_pend;
      end else m_cnt++;
      nf++;
   endtask

   task automatic push_clear();
      exp_t e;
      e.bits = '0;
      e.ps = 0;
      e.wrap = 0;
      e.clr = 1;
      q.push_back(e);
      nf++;
   endtask

   task automatic wait_until(input int t);
      while (cyc < t) @(negedge clk);
      #2;
   endtask

   task automatic run(input int n);
      repeat (n) push_frame();
      wait_until(t_en + FL * nf);
   endtask

   task automatic restart();
      m_act = m_pend;
      m_cnt = 0;
      last_ps = -1;
      enable = 1;
      t_en = cyc;
      nf = 0;
   endtask

   task automatic write(input int c, input int d);
      bit acc;
      acc = 0;
      @(negedge clk);
      cfg.cfg_valid = 1;
      cfg.cfg_chan = CW'(c);
      cfg.cfg_duty = DW'(d);
      for (int i = 0; i < 4 && !acc; i++) begin
         acc = cfg.cfg_ready;
         @(negedge clk);
      end
      cfg.cfg_valid = 0;
      chk("cfg_accept", int'(acc), 1);
      if (acc && c < NCH) m_pend[c] = d;
   endtask

   task automatic stop();
      int f;
      f = nf;
      push_frame();
      wait_until(t_en + FL * f + 3);
      enable = 0;
      push_clear();
      wait_until(t_en + FL * f + 2 * FL + 1);
      chk("busy_after_clear", int'(busy), 0);
      chk("shift_after_clear", int'(sr_shift), 0);
   endtask

   initial begin
      #400000;
      $display("FAIL timeout: simulation did not finish (cycle %0d)", cyc);
      $fatal(1, "timeout");
   end

   initial begin
      tbl[0] = '{0, 25, 25};
      tbl[1] = '{1, 40, 40};
      tbl[2] = '{2, 50, 50};
      tbl[3] = '{3, 65, 65};
      tbl[4] = '{4, 70, 70};
      tbl[5] = '{5, 80, 80};
      tbl[6] = '{6, 90, 90};
      tbl[7] = '{7, 15, 15};
      tbl[8] = '{0, 0, 0};
      tbl[9] = '{1, 100, 100};
      tbl[10] = '{2, 255, 100};
      tbl[11] = '{3, 10, 10};
      m_pend = '{default: 0};
      m_act = '{default: 0};
      hits = '{default: 0};
      cfg.cfg_valid = 0;
      cfg.cfg_chan = '0;
      cfg.cfg_duty = '0;
      repeat (3) @(negedge clk);
      reset = 0;
      chk("rst_sr_data", int'(sr_data), 0);
      chk("rst_sr_shift", int'(sr_shift), 0);
      chk("rst_sr_latch", int'(sr_latch), 0);
      chk("rst_period_start", int'(period_start), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_cfg_ready", int'(cfg.cfg_ready), 1);
      repeat (50) @(negedge clk);
      chk("idle_shifts", nsh, 0);
      chk("idle_busy", int'(busy), 0);
      for (int i = 0; i < 7; i++) write(tbl[i].chan, tbl[i].duty);
      // back-to-back writes to channel 7: the second must win
      @(negedge clk);
      cfg.cfg_valid = 1;
      cfg.cfg_chan = CW'(7);
      cfg.cfg_duty = DW'(33);
      @(negedge clk);
      cfg.cfg_duty = DW'(tbl[7].duty);
      @(negedge clk);
      cfg.cfg_valid = 0;
      m_pend[7] = tbl[7].duty;
      repeat (2) @(negedge clk);
      #2;
      hits = '{default: 0};
      restart();
      run(PERIOD);
      for (int i = 0; i < 8; i++) chk("hits_p1", hits[tbl[i].chan], tbl[i].hits);
      hits = '{default: 0};
      for (int i = 8; i < 11; i++) write(tbl[i].chan, tbl[i].duty);
      run(37);
      write(tbl[11].chan, tbl[11].duty);
      run(PERIOD - 37);
      for (int i = 0; i < 8; i++) chk("hits_p2", hits[tbl[i].chan], tbl[i].hits);
      for (int i = 0; i < 12; i++) exp3[tbl[i].chan] = tbl[i].hits;
      hits = '{default: 0};
      run(PERIOD);
      for (int i = 0; i < NCH; i++) chk("hits_p3", hits[i], exp3[i]);
      run(5);
      stop();
      restart();
      run(2);
      wait_until(t_en + FL * 2 + 4);
      reset = 1;
      enable = 0;
      @(negedge clk);
      #2;
      chk("rst_mid_shift", int'(sr_shift), 0);
      chk("rst_mid_busy", int'(busy), 0);
      chk("rst_mid_latch", int'(sr_latch), 0);
      chk("rst_mid_ready", int'(cfg.cfg_ready), 1);
      reset = 0;
      m_pend = '{default: 0};
      restart();
      hits = '{default: 0};
      run(3);
      for (int i = 0; i < NCH; i++) chk("hits_after_reset", hits[i], 0);
      repeat (5) @(negedge clk);
      chk("queue_empty", q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
